// File: rtl/barrel_shift_pipe.sv
// Two-stage SLL/SRL/SRA/ROR shifter: low amount bits in S1, high bits in S2; results leave 2 edges after acceptance,
// one op per cycle, and a stalled output holds both stages. Define BARREL_SHIFT_FLAGS_EN for {Z,N,C} flags (else 0).
module barrel_shift_pipe #(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_flags
);

  localparam int LO = (SHW + 1) / 2;
  localparam int HI = SHW - LO;
  localparam logic [SHW:0] WBITS = (SHW + 1)'(WIDTH);

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;

  function automatic logic [WIDTH-1:0] shift_data(
    input logic [WIDTH-1:0] d,
    input logic [SHW-1:0]   a,
    input logic [1:0]       m
  );
    logic signed [WIDTH-1:0] sd;
    sd = d;
    case (m)
      MODE_SLL: shift_data = d << a;
      MODE_SRL: shift_data = d >> a;
      MODE_SRA: shift_data = sd >>> a;
      default:  shift_data = (d >> a) | (d << (WBITS - {1'b0, a}));
    endcase
  endfunction

  logic             s1_vld;
  logic [WIDTH-1:0] s1_data;
  logic [HI-1:0]    s1_hi;
  logic [1:0]       s1_mode;
  logic             s2_vld;
  logic [WIDTH-1:0] s2_data;

  logic             s1_load;
  logic             s2_load;
  logic             in_fire;
  logic [SHW-1:0]   amt1;
  logic [SHW-1:0]   amt2;
  logic [WIDTH-1:0] s1_res;
  logic [WIDTH-1:0] s2_res;

  assign s2_load  = !s2_vld || out_ready;
  assign s1_load  = !s1_vld || s2_load;
  assign in_ready = rst_n && !flush && s1_load;
  assign in_fire  = in_valid && in_ready;

  assign amt1   = {{HI{1'b0}}, in_amt[LO-1:0]};
  assign amt2   = {s1_hi, {LO{1'b0}}};
  assign s1_res = shift_data(in_data, amt1, in_mode);
  assign s2_res = shift_data(s1_data, amt2, s1_mode);

  assign out_valid = s2_vld;
  assign out_data  = s2_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else if (flush) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else begin
      if (s2_load) s2_vld <= s1_vld;
      if (s1_load) s1_vld <= in_fire;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data <= '0;
      s1_hi   <= '0;
      s1_mode <= 2'b00;
      s2_data <= '0;
    end else begin
      if (in_fire) begin
        s1_data <= s1_res;
        s1_hi   <= in_amt[SHW-1:LO];
        s1_mode <= in_mode;
      end
      if (s2_load && s1_vld) s2_data <= s2_res;
    end
  end

`ifdef BARREL_SHIFT_FLAGS_EN
  // A zero partial amount passes the carry of the earlier stage through unchanged.
  function automatic logic shift_carry(
    input logic [WIDTH-1:0] d,
    input logic [SHW-1:0]   a,
    input logic [1:0]       m,
    input logic             cin
  );
    logic [SHW-1:0]   up;
    logic [SHW-1:0]   dn;
    logic [WIDTH-1:0] r;
    up = ~a + 1'b1;
    dn = a - 1'b1;
    r  = shift_data(d, a, m);
    if (a == '0) begin
      shift_carry = cin;
    end else begin
      case (m)
        MODE_SLL: shift_carry = d[up];
        MODE_SRL: shift_carry = d[dn];
        MODE_SRA: shift_carry = d[dn];
        default:  shift_carry = r[WIDTH-1];
      endcase
    end
  endfunction

  logic       s1_c;
  logic [2:0] s2_flags;
  logic       s2_c;

  assign s2_c      = shift_carry(s1_data, amt2, s1_mode, s1_c);
  assign out_flags = s2_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_c     <= 1'b0;
      s2_flags <= 3'b000;
    end else begin
      if (in_fire) s1_c <= shift_carry(in_data, amt1, in_mode, 1'b0);
      if (s2_load && s1_vld) s2_flags <= {s2_res == '0, s2_res[WIDTH-1], s2_c};
    end
  end
`else
  assign out_flags = 3'b000;
`endif

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Randomized and directed bench for barrel_shift_pipe (WIDTH=16) against an arithmetic reference and an ordered queue.
module tb_barrel_shift_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0;
  logic [3:0]  in_amt = 4'h0;
  logic [1:0]  in_mode = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [2:0]  out_flags;

  barrel_shift_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [2:0]  f;
    int          t;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pops = 0;
  logic        fired = 1'b0;
  logic        dir_en = 1'b0;
  logic [15:0] dir_d = 16'h0;
  logic [2:0]  dir_f = 3'b000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Reference: {flags, data} from the operation rules; flags are zero when the feature is compiled out.
  function automatic logic [18:0] ref_op(input logic [15:0] d, input logic [3:0] a, input logic [1:0] m);
    logic [31:0]        wide;
    logic signed [31:0] sx;
    logic [15:0]        r;
    logic               c;
    logic [2:0]         f;
    wide = {16'h0, d};
    sx   = {{16{d[15]}}, d};
    r    = 16'h0;
    c    = 1'b0;
    case (m)
      2'd0: begin wide = wide << a; r = wide[15:0]; c = wide[16]; end
      2'd1: begin r = d >> a; c = (a != 4'd0) && d[a - 4'd1]; end
      2'd2: begin sx = sx >>> a; r = sx[15:0]; c = (a != 4'd0) && d[a - 4'd1]; end
      default: begin wide = {d, d} >> a; r = wide[15:0]; c = (a != 4'd0) && r[15]; end
    endcase
`ifdef BARREL_SHIFT_FLAGS_EN
    f = {r == 16'h0, r[15], c};
`else
    f = 3'b000;
`endif
    return {f, r};
  endfunction

  // One clock: check outputs against the model, update the model for this edge, advance to the next negedge.
  // An operand accepted at edge t may leave at edge t+2 at the earliest, so it is visible once cyc >= t+1.
  task automatic cycle();
    logic        exp_ov;
    logic        exp_rdy;
    logic [18:0] r;
    exp_t        e;
    #1;
    exp_ov  = (q.size() > 0) && (cyc >= q[0].t + 1);
    exp_rdy = !flush && ((q.size() < 2) || out_ready);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, exp_ov);
    if (exp_ov) begin
      chk("out_data", out_data, q[0].d);
      chk("out_flags", out_flags, q[0].f);
    end
    if (exp_ov && out_ready) begin
      void'(q.pop_front());
      pops++;
    end
    fired = 1'b0;
    if (flush) begin
      q.delete();
    end else if (in_valid && exp_rdy) begin
      fired = 1'b1;
      r = ref_op(in_data, in_amt, in_mode);
      e.d = dir_en ? dir_d : r[15:0];
      e.f = dir_en ? dir_f : r[18:16];
      e.t = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic op(input logic [15:0] d, input logic [3:0] a, input logic [1:0] m,
                    input logic [15:0] ed, input logic [2:0] ef);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_mode  = m;
    dir_en   = 1'b1;
    dir_d    = ed;
`ifdef BARREL_SHIFT_FLAGS_EN
    dir_f    = ef;
`else
    dir_f    = 3'b000;
`endif
    cycle();
    dir_en   = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic rand_op();
    in_valid = 1'b1;
    in_data  = 16'($urandom);
    in_amt   = 4'($urandom_range(0, 15));
    in_mode  = 2'($urandom_range(0, 3));
  endtask

  initial begin
    int k;
    int g;
    int p0;

    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_data", out_data, 16'h0);
    chk("rst_out_flags", out_flags, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    cycle();

    // Directed cases, streamed back to back.
    op(16'h8001, 4'd1,  2'd0, 16'h0002, 3'b001);
    op(16'h8000, 4'd15, 2'd2, 16'hFFFF, 3'b010);
    op(16'h8000, 4'd15, 2'd1, 16'h0001, 3'b000);
    op(16'h1234, 4'd4,  2'd3, 16'h4123, 3'b000);
    op(16'h0001, 4'd1,  2'd3, 16'h8000, 3'b011);
    for (int m = 0; m < 4; m++) op(16'hA5A5, 4'd0, 2'(m), 16'hA5A5, 3'b010);
    idle(3);

    // 0x0001 SLL 0..15 with a 4-cycle output stall in the middle.
    k = 0;
    g = 0;
    p0 = pops;
    while (k < 16 && g < 200) begin
      in_valid  = 1'b1;
      in_data   = 16'h0001;
      in_amt    = k[3:0];
      in_mode   = 2'd0;
      out_ready = !(g >= 6 && g < 10);
      cycle();
      if (fired) k++;
      g++;
    end
    out_ready = 1'b1;
    idle(4);
    chk("stream_count", pops - p0, 16);

    // Flush with two operations in flight, then a normal operand.
    out_ready = 1'b0;
    rand_op(); cycle();
    rand_op(); cycle();
    in_valid = 1'b0;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    out_ready = 1'b1;
    cycle();
    rand_op(); cycle();
    idle(3);

    // Asynchronous reset with two operations in flight.
    out_ready = 1'b0;
    rand_op(); cycle();
    rand_op(); cycle();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_out_data", out_data, 16'h0);
    chk("arst_out_flags", out_flags, 3'b000);
    chk("arst_in_ready", in_ready, 1'b0);
    q.delete();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(4);

    // Random traffic with random backpressure and occasional flush.
    for (int i = 0; i < 600; i++) begin
      rand_op();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      cycle();
    end
    flush = 1'b0;
    out_ready = 1'b1;
    idle(4);
    chk("drain_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
